cordic_phase_gen: RTL
=====================

Name: cordic_phase_gen

Overview:
- Numerically-controlled phase generator; sits directly upstream of the parallel CORDIC cos/sin stage.
- Produces the `phi` angle and the `st` start strobe that stage consumes.
- Phase accumulator runs at a programmable sample rate (one sample every div+1 enabled clocks).
- Frequency word and phase offset are double-buffered so updates land only on sample boundaries.
- Output phase is rounded to PHI_WDT bits; full-scale 2^PHI_WDT represents 2*pi.

Parameters:
- ACC_WDT, 32: phase accumulator width; must be > PHI_WDT.
- PHI_WDT, 16: output angle width; must equal the downstream CORDIC PHI_WDT.
- DIV_WDT, 16: sample-rate divider width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low (asserted at 0)
- sclr  in  1  synchronous clear, effective only when en=1
- en  in  1  clock enable, shared with downstream CORDIC
- div  in  DIV_WDT  sample period minus 1, in enabled clocks; sampled at each reload
- frqWr  in  1  write strobe for frqIn/ofsIn
- frqIn  in  ACC_WDT  phase increment per sample (unsigned, mod 2^ACC_WDT)
- ofsIn  in  PHI_WDT  phase offset added to output phase
- syncPhs  in  1  request accumulator restart at next sample
- frqPend  out  1  shadow write not yet applied
- st  out  1  start strobe to CORDIC, one enabled cycle per sample
- phi  out  PHI_WDT  angle to CORDIC, unsigned 0..2*pi

Behaviour:
- Reset (reset=0), any time, including mid-operation: all state and outputs are 0. This covers acc, divCnt, frqSh, ofsSh, frqAct, ofsAct, frqPend, syncPend, st and phi.
- en=0: all registers hold. st holds its value; the downstream stage samples st only on en cycles, so each sample is seen exactly once.
- sclr=1 with en=1: same clear as reset, and it has priority over frqWr, syncPhs and tick.
- Tick generation:
  - tick = en & (divCnt==0).
  - On tick: divCnt <= div. Otherwise, when en=1: divCnt <= divCnt-1.
  - divCnt=0 after reset, so the first enabled cycle ticks.
  - div=0 gives a tick every enabled cycle.
- Shadow write, frqWr with en=1:
  - frqSh <= frqIn, ofsSh <= ofsIn, frqPend <= 1.
  - Applied at the next tick after the write cycle.
- Effective values: frqEff = frqPend ? frqSh : frqAct; ofsEff likewise. On a tick with frqPend=1: frqAct <= frqSh, ofsAct <= ofsSh, frqPend <= 0.
- Simultaneous frqWr and tick: the previous shadow contents are applied on this tick. The new write goes to the shadow and frqPend stays 1.
- syncPhs with en=1 sets syncPend; it is consumed on the next tick, including a tick in the same cycle.
- On tick, with accEff = syncPend ? 0 : acc:
  - phi <= accEff[ACC_WDT-1 -: PHI_WDT] + accEff[ACC_WDT-PHI_WDT-1] + ofsEff, all mod 2^PHI_WDT (round half up, wrap).
  - acc <= accEff + frqEff, mod 2^ACC_WDT.
  - syncPend <= 0.
  - st <= 1.
- Non-tick enabled cycle: st <= 0; phi holds.
- Latency: phi/st are registered, valid the cycle after the tick. Sample k carries the accumulator value before increment k.

Decomposition:
- Shared package holds:
  - the phase/frequency typedefs sized by ACC_WDT/PHI_WDT;
  - the rounding function (top PHI_WDT bits plus guard bit, wrapping);
  - a width-check constant asserting ACC_WDT > PHI_WDT.
- One sub-module, cordic_tick_gen: the div reload down-counter with en/sclr, outputting tick.

Test Plan:
Common setup: ACC_WDT=32, PHI_WDT=16, en=1 unless stated.
- Basic rate: release reset, div=0, frqWr frqIn=0x0100_0000, ofsIn=0 -> frqPend clears at next tick; phi sequence 0x0000, 0x0100, 0x0200…, st=1 every cycle.
- Divider: same config with div=3 -> st high 1 of every 4 cycles; phi steps by 0x0100 per st; st never high on consecutive cycles.
- Rounding: frqIn=0x0000_8000 -> phi 0x0000, 0x0001, 0x0001, 0x0002.
- Wrap and offset: frqIn=0x4000_0000, ofsIn=0x2000 -> phi 0x2000, 0x6000, 0xA000, 0xE000, 0x2000.
- Boundaries:
  - frqWr coincident with a tick under div=3 -> old shadow applied, frqPend stays 1, new value applied 4 cycles later.
  - syncPhs mid-run -> next phi equals ofsAct.
  - en=0 for 5 cycles -> phi/st/acc frozen.
  - sclr -> all outputs 0 next cycle.
- Reset mid-run: reset=0 asynchronously between clock edges -> all outputs 0 immediately. After release, the first tick gives phi=0x0000 and frqPend=0.

Source files
------------

// File: rtl/cordic_phase_gen_pkg.sv
// Shared types, width checks and phase rounding for the CORDIC phase generator.
package cordic_phase_gen_pkg;

  localparam int unsigned AccWdtDflt = 32;
  localparam int unsigned PhiWdtDflt = 16;

  // The guard bit below the output field must exist.
  localparam bit WidthOk = AccWdtDflt > PhiWdtDflt;

  typedef logic [AccWdtDflt-1:0] acc_t;
  typedef logic [PhiWdtDflt-1:0] phi_t;

  // acc_al is the accumulator left-aligned to bit 63; the caller truncates the
  // result to phi_wdt bits, which makes a round-up from all-ones wrap to zero.
  function automatic logic [63:0] round_phase(input logic [63:0] acc_al,
                                              input int unsigned phi_wdt);
    logic [63:0] top_bits;
    logic [63:0] guard;
    top_bits = acc_al >> (64 - phi_wdt);
    guard    = (acc_al >> (63 - phi_wdt)) & 64'd1;
    return top_bits + guard;
  endfunction

endpackage

// File: rtl/cordic_tick_gen.sv
// Sample-rate divider: reloads from div_i on each tick, counts down on enabled clocks.
module cordic_tick_gen #(
  parameter int unsigned DIV_WDT = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               sclr_i,
  input  logic [DIV_WDT-1:0] div_i,
  output logic               tick_o
);

  logic [DIV_WDT-1:0] cnt_d, cnt_q;

  assign tick_o = en_i && !sclr_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (sclr_i) begin
        cnt_d = '0;
      end else if (cnt_q == '0) begin
        cnt_d = div_i;
      end else begin
        cnt_d = cnt_q - DIV_WDT'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Numerically-controlled phase generator feeding phi/st to the CORDIC cos/sin stage.
module cordic_phase_gen
  import cordic_phase_gen_pkg::*;
#(
  parameter int unsigned ACC_WDT = AccWdtDflt,
  parameter int unsigned PHI_WDT = PhiWdtDflt,
  parameter int unsigned DIV_WDT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclr,
  input  logic               en,
  input  logic [DIV_WDT-1:0] div,
  input  logic               frqWr,
  input  logic [ACC_WDT-1:0] frqIn,
  input  logic [PHI_WDT-1:0] ofsIn,
  input  logic               syncPhs,
  output logic               frqPend,
  output logic               st,
  output logic [PHI_WDT-1:0] phi
);

  if (!(ACC_WDT > PHI_WDT) || (ACC_WDT > 64) || !WidthOk) begin : g_width_err
    $error("cordic_phase_gen: need PHI_WDT < ACC_WDT <= 64");
  end

  logic tick;

  cordic_tick_gen #(
    .DIV_WDT(DIV_WDT)
  ) u_tick_gen (
    .clk_i (clk),
    .rst_ni(reset),
    .en_i  (en),
    .sclr_i(sclr),
    .div_i (div),
    .tick_o(tick)
  );

  logic [ACC_WDT-1:0] acc_d, acc_q;
  logic [ACC_WDT-1:0] frq_sh_d, frq_sh_q, frq_act_d, frq_act_q;
  logic [PHI_WDT-1:0] ofs_sh_d, ofs_sh_q, ofs_act_d, ofs_act_q;
  logic [PHI_WDT-1:0] phi_d, phi_q;
  logic               frq_pend_d, frq_pend_q;
  logic               sync_pend_d, sync_pend_q;
  logic               st_d, st_q;

  logic [ACC_WDT-1:0] frq_eff, acc_eff;
  logic [PHI_WDT-1:0] ofs_eff, phi_round;

  assign frq_eff   = frq_pend_q ? frq_sh_q : frq_act_q;
  assign ofs_eff   = frq_pend_q ? ofs_sh_q : ofs_act_q;
  // A sync request in the tick cycle itself already restarts this sample.
  assign acc_eff   = (sync_pend_q || syncPhs) ? '0 : acc_q;
  assign phi_round = PHI_WDT'(round_phase(64'(acc_eff) << (64 - ACC_WDT), PHI_WDT));

  always_comb begin
    acc_d       = acc_q;
    frq_sh_d    = frq_sh_q;
    ofs_sh_d    = ofs_sh_q;
    frq_act_d   = frq_act_q;
    ofs_act_d   = ofs_act_q;
    frq_pend_d  = frq_pend_q;
    sync_pend_d = sync_pend_q;
    st_d        = st_q;
    phi_d       = phi_q;
    if (en) begin
      if (sclr) begin
        acc_d       = '0;
        frq_sh_d    = '0;
        ofs_sh_d    = '0;
        frq_act_d   = '0;
        ofs_act_d   = '0;
        frq_pend_d  = 1'b0;
        sync_pend_d = 1'b0;
        st_d        = 1'b0;
        phi_d       = '0;
      end else begin
        if (tick) begin
          phi_d       = phi_round + ofs_eff;
          acc_d       = acc_eff + frq_eff;
          sync_pend_d = 1'b0;
          st_d        = 1'b1;
          if (frq_pend_q) begin
            frq_act_d  = frq_sh_q;
            ofs_act_d  = ofs_sh_q;
            frq_pend_d = 1'b0;
          end
        end else begin
          st_d = 1'b0;
          if (syncPhs) begin
            sync_pend_d = 1'b1;
          end
        end
        // Placed after the tick apply so a coincident write stays pending.
        if (frqWr) begin
          frq_sh_d   = frqIn;
          ofs_sh_d   = ofsIn;
          frq_pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      frq_sh_q    <= '0;
      ofs_sh_q    <= '0;
      frq_act_q   <= '0;
      ofs_act_q   <= '0;
      frq_pend_q  <= 1'b0;
      sync_pend_q <= 1'b0;
      st_q        <= 1'b0;
      phi_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      frq_sh_q    <= frq_sh_d;
      ofs_sh_q    <= ofs_sh_d;
      frq_act_q   <= frq_act_d;
      ofs_act_q   <= ofs_act_d;
      frq_pend_q  <= frq_pend_d;
      sync_pend_q <= sync_pend_d;
      st_q        <= st_d;
      phi_q       <= phi_d;
    end
  end

  assign frqPend = frq_pend_q;
  assign st      = st_q;
  assign phi     = phi_q;

endmodule
